ccff_bitstream_loader: RTL
==========================

Name: ccff_bitstream_loader

Overview:
- Upstream feeder of the configuration-chain head (ccff_head) of a tile column, e.g. the io logical tiles and the CLBs behind them.
- Accepts configuration words from the host/SoC over a valid/ready stream and serializes them LSB-first onto the chain.
- Counts exactly CHAIN_LEN shifted bits and gates the chain's shift enable, so the chain only advances on real data.
- Reports busy/done to the host.

Parameters:
- CHAIN_LEN, 1024: total configuration bits in the downstream chain, ≥ 1.
- WORD_W, 32: host word width in bits, ≥ 2.
- CNT_W, $clog2(CHAIN_LEN+1): width of the bit counter (derived; do not override).

Ports:
- prog_clk  in  1  programming clock, shared with the chain.
- pReset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a load. Ignored unless in IDLE or DONE.
- word_valid  in  1  host word available.
- word_data  in  WORD_W  host word; bit 0 is shifted first.
- word_ready  out  1  loader accepts word_data this cycle.
- ccff_head  out  1  serial config bit into the chain (registered).
- ccff_tail  in  1  serial bit returned from the chain end.
- chain_shift_en  out  1  chain flops capture on this prog_clk edge when high (registered).
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  level; high in DONE.
- err  out  1  verify mismatch flag. Tied 0 without the optional feature.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=IDLE; all outputs 0.
  - Shift register, bit counter, word-bit index cleared.
- States: IDLE, FETCH, SHIFT, DONE (plus VERIFY when the optional feature is compiled in).
- IDLE/DONE:
  - start=1 → FETCH; bit_cnt=0; done=0; err=0.
  - Other inputs ignored; word_ready=0.
- FETCH:
  - word_ready=1 and chain_shift_en=0, so the chain holds.
  - On word_valid&&word_ready: capture word_data into sreg, word_idx=0 → SHIFT.
- SHIFT, once per cycle:
  - ccff_head<=sreg[0]; chain_shift_en<=1; sreg>>=1; bit_cnt++; word_idx++.
  - The registered head and enable are presented together, so the chain captures bit k one cycle after the loader issues it.
- SHIFT exit conditions:
  - bit_cnt reaches CHAIN_LEN-1 on the issuing cycle (last bit) → DONE, or → VERIFY when the feature is present. The remaining bits of a partial last word are discarded.
  - Else if word_idx==WORD_W-1 → FETCH. A one-cycle bubble per word minimum is allowed; chain_shift_en=0 during bubbles.
- Simultaneous events:
  - word_valid is not sampled in SHIFT.
  - A start pulse while busy is ignored. No abort exists; only reset stops a load.
- Reset mid-load: everything clears immediately. The chain holds a partial configuration; the host must restart.
- Throughput: WORD_W shifts per (WORD_W + 1 + host-stall) cycles.
- done deasserts only on the next accepted start or on reset.

Optional Feature:
- Macro: CCFF_READBACK_VERIFY_EN.
- With the macro:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first update, one bit per shift) runs over every bit issued in SHIFT.
  - VERIFY state: CHAIN_LEN more cycles with chain_shift_en=1 and ccff_head<=ccff_tail (recirculate). The chain content is unchanged at the end.
  - A second CRC runs over the sampled ccff_tail bits.
  - At the end of VERIFY → DONE; err=1 if the CRCs differ. err holds until the next start.
  - busy stays high through VERIFY.
- Without the macro: no VERIFY state; err tied 0; ccff_tail unused.

Decomposition:
- Package ccff_loader_pkg:
  - state enum.
  - CRC16_POLY=16'h1021 and CRC16_INIT=16'hFFFF.
  - Function crc16_step(crc, bit).
- Sub-module ccff_crc16_ser: one-bit serial CRC, enable and clear inputs. Instantiated twice when the feature is on; not instantiated when off.

Test Plan (CHAIN_LEN=40, WORD_W=16, behavioural 40-bit shift-register chain model):
1. Reset while idle → all outputs 0, word_ready=0. Pulse start → word_ready=1 next cycle.
2. Words 0xA5C3, 0x0FF0, 0x1234 with word_valid held high → exactly 40 chain_shift_en cycles, two FETCH bubbles. Chain model holds bits 0xA5C3 | 0x0FF0<<16 | (0x1234&0xFF)<<32. done=1, busy=0.
3. Same load, host deasserts word_valid for 5 cycles before word 2 → chain_shift_en=0 for those cycles; final chain content identical to scenario 2.
4. Assert pReset_n=0 after 20 shifts → outputs 0 asynchronously. Restart with scenario 2 stimulus → correct full content.
5. start pulsed during SHIFT → ignored. Shift count still 40; done asserts once.
6. (CCFF_READBACK_VERIFY_EN) Clean chain: after 80 total enabled cycles, err=0 and content unchanged. Model flips chain bit 7 during VERIFY: err=1, done=1.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-16-CCITT helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_VERIFY = 3'd4
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // MSB-first update with one data bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/ccff_crc16_ser.sv
// One-bit-per-cycle serial CRC-16-CCITT accumulator with synchronous clear.
module ccff_crc16_ser
  import ccff_loader_pkg::*;
(
  input  logic        prog_clk,
  input  logic        pReset_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic [15:0] crc_reg;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      crc_reg <= CRC16_INIT;
    end else if (clr) begin
      crc_reg <= CRC16_INIT;
    end else if (en) begin
      crc_reg <= crc16_step(crc_reg, din);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes host words LSB-first onto a configuration chain head, gating the chain shift enable.
// Optional read-back CRC check of the chain is compiled in with CCFF_READBACK_VERIFY_EN.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int  CHAIN_LEN = 1024,
  parameter int  WORD_W    = 32,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              chain_shift_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  state_t            state_reg, state_next;
  logic [WORD_W-1:0] sreg_reg, sreg_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [IDX_W-1:0]  word_idx_reg, word_idx_next;
  logic              head_reg, head_next;
  logic              shift_en_reg, shift_en_next;

`ifdef CCFF_READBACK_VERIFY_EN
  localparam logic [CNT_W-1:0] VERIFY_END = CNT_W'(CHAIN_LEN);
  logic        err_reg, err_next;
  logic        recirc_reg, recirc_next;
  logic        crc_clr, crc_a_en;
  logic [15:0] crc_a, crc_b;

  ccff_crc16_ser u_crc_issue (
    .prog_clk (prog_clk), .pReset_n (pReset_n), .clr (crc_clr),
    .en (crc_a_en), .din (sreg_reg[0]), .crc (crc_a)
  );

  // recirc_reg marks cycles where the chain captures its own tail, so the tail is sampled exactly then.
  ccff_crc16_ser u_crc_tail (
    .prog_clk (prog_clk), .pReset_n (pReset_n), .clr (crc_clr),
    .en (recirc_reg), .din (ccff_tail), .crc (crc_b)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_reg    <= ST_IDLE;
      sreg_reg     <= '0;
      bit_cnt_reg  <= '0;
      word_idx_reg <= '0;
      head_reg     <= 1'b0;
      shift_en_reg <= 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
      err_reg      <= 1'b0;
      recirc_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      sreg_reg     <= sreg_next;
      bit_cnt_reg  <= bit_cnt_next;
      word_idx_reg <= word_idx_next;
      head_reg     <= head_next;
      shift_en_reg <= shift_en_next;
`ifdef CCFF_READBACK_VERIFY_EN
      err_reg      <= err_next;
      recirc_reg   <= recirc_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    sreg_next     = sreg_reg;
    bit_cnt_next  = bit_cnt_reg;
    word_idx_next = word_idx_reg;
    head_next     = head_reg;
    shift_en_next = 1'b0;
    word_ready    = 1'b0;
`ifdef CCFF_READBACK_VERIFY_EN
    err_next      = err_reg;
    recirc_next   = 1'b0;
    crc_clr       = 1'b0;
    crc_a_en      = 1'b0;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next   = ST_FETCH;
          bit_cnt_next = '0;
`ifdef CCFF_READBACK_VERIFY_EN
          err_next     = 1'b0;
          crc_clr      = 1'b1;
`endif
        end
      end
      ST_FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          sreg_next     = word_data;
          word_idx_next = '0;
          state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        head_next     = sreg_reg[0];
        shift_en_next = 1'b1;
        sreg_next     = sreg_reg >> 1;
        bit_cnt_next  = bit_cnt_reg + 1'b1;
        word_idx_next = word_idx_reg + 1'b1;
`ifdef CCFF_READBACK_VERIFY_EN
        crc_a_en      = 1'b1;
`endif
        // Last chain bit wins over end-of-word: leftover bits of a partial word are dropped.
        if (bit_cnt_reg == LAST_BIT) begin
`ifdef CCFF_READBACK_VERIFY_EN
          state_next   = ST_VERIFY;
          bit_cnt_next = '0;
`else
          state_next   = ST_DONE;
`endif
        end else if (word_idx_reg == LAST_IDX) begin
          state_next = ST_FETCH;
        end
      end
`ifdef CCFF_READBACK_VERIFY_EN
      // The first cycle only lets the final issued bit land; the extra cycle at the end folds
      // the last returning bit into the comparison.
      ST_VERIFY: begin
        if (bit_cnt_reg != VERIFY_END) begin
          shift_en_next = 1'b1;
          recirc_next   = 1'b1;
          bit_cnt_next  = bit_cnt_reg + 1'b1;
        end else begin
          state_next = ST_DONE;
          err_next   = (crc_a != crc16_step(crc_b, ccff_tail));
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef CCFF_READBACK_VERIFY_EN
  // During recirculation the tail flop feeds the head directly so the loop stays CHAIN_LEN long.
  assign ccff_head = recirc_reg ? ccff_tail : head_reg;
  assign err       = err_reg;
`else
  assign ccff_head = head_reg;
  assign err       = 1'b0;
`endif
  assign chain_shift_en = shift_en_reg;
  assign busy           = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done           = (state_reg == ST_DONE);

endmodule
